// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding load/store unit driving one AXI4-lite read or write per request
module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TIMEOUT = 255,
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic [1:0]            resp_err,
    output logic                  busy,
    output logic [ADDR_W-1:0]     axi_awaddr,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_W-1:0]     axi_wdata,
    output logic [DATA_W/8-1:0]   axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ADDR_W-1:0]     axi_araddr,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_W-1:0]     axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready
);
    localparam int SW = DATA_W / 8;
    localparam int OW = $clog2(SW);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;
    state_t state_q, state_d;
    logic [1:0] size_q;
    logic signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [OW-1:0] off_q;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] wdog_q, wdog_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0] err_q, err_d;
    logic illegal, timeout, sbit;
    logic [DATA_W-1:0] sh, lmask, ld;
    logic [SW-1:0] bmask;
    assign req_ready = state_q == IDLE;
    assign busy = ~req_ready;
    assign resp_valid = state_q == DONE;
    assign resp_rdata = rdata_q;
    assign resp_err = err_q;
    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_awprot = PROT;
    assign axi_arprot = PROT;
    assign axi_awvalid = state_q == WADDR && !aw_done_q;
    assign axi_wvalid = state_q == WADDR && !w_done_q;
    assign axi_bready = state_q == WRESP;
    assign axi_arvalid = state_q == RADDR;
    assign axi_rready = state_q == RDATA;
    assign axi_wdata = wdata_q << {off_q, 3'b000};
    assign bmask = SW'((16'd1 << (5'd1 << size_q)) - 16'd1);
    assign axi_wstrb = bmask << off_q;
    always_comb begin
        illegal = |(req_addr[2:0] & 3'((4'd1 << req_size) - 4'd1)) || (req_size == 2'd3 && DATA_W == 32);
        timeout = TIMEOUT != 0 && (wdog_q + 32'd2 >= 32'(TIMEOUT));
        sh = axi_rdata >> {off_q, 3'b000};
        lmask = size_q == 2'd0 ? DATA_W'(8'hFF) : size_q == 2'd1 ? DATA_W'(16'hFFFF) :
                size_q == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
        // top bit of the mask selects the sign bit of the loaded quantity
        sbit = |(sh & lmask & ~(lmask >> 1));
        ld = (sh & lmask) | ({DATA_W{signed_q & sbit}} & ~lmask);
    end
    always_comb begin
        state_d = state_q;
        aw_done_d = aw_done_q;
        w_done_d = w_done_q;
        wdog_d = (state_q != IDLE && state_q != DONE) ? wdog_q + 32'd1 : wdog_q;
        rdata_d = rdata_q;
        err_d = err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                wdog_d = '0;
                aw_done_d = 1'b0;
                w_done_d = 1'b0;
                state_d = illegal ? DONE : req_we ? WADDR : RADDR;
                if (illegal) begin
                    err_d = 2'b01;
                    rdata_d = '0;
                end
            end
            WADDR: begin
                aw_done_d = aw_done_q | axi_awready;
                w_done_d = w_done_q | axi_wready;
                if (aw_done_d && w_done_d) state_d = WRESP;
                else if (timeout) state_d = DONE;
            end
            WRESP: if (axi_bvalid) begin
                state_d = DONE;
                err_d = axi_bresp != 2'b00 ? 2'b10 : 2'b00;
                rdata_d = '0;
            end else if (timeout) state_d = DONE;
            RADDR: if (axi_arready) state_d = RDATA;
                else if (timeout) state_d = DONE;
            RDATA: if (axi_rvalid) begin
                state_d = DONE;
                err_d = axi_rresp != 2'b00 ? 2'b10 : 2'b00;
                rdata_d = axi_rresp != 2'b00 ? '0 : ld;
            end else if (timeout) state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && state_q != DONE && state_d == DONE && timeout
            && !(state_q == WADDR && aw_done_d && w_done_d)
            && !(state_q == WRESP && axi_bvalid) && !(state_q == RDATA && axi_rvalid)) begin
            err_d = 2'b11;
            rdata_d = '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q <= 1'b0;
            wdog_q <= '0;
            rdata_q <= '0;
            err_q <= '0;
            size_q <= '0;
            signed_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            off_q <= '0;
        end else begin
            state_q <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q <= w_done_d;
            wdog_q <= wdog_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            if (state_q == IDLE && req_valid) begin
                size_q <= req_size;
                signed_q <= req_signed;
                addr_q <= req_addr;
                wdata_q <= req_wdata;
                off_q <= req_addr[OW-1:0];
            end
        end
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: scoreboard bench with a cycle-stepped AXI4-lite slave model
module tb_lsu_axi_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic req_valid = 0, req_ready, req_we = 0, req_signed = 0;
    logic [1:0] req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic resp_valid, busy;
    logic [31:0] resp_rdata;
    logic [1:0] resp_err;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata;
    logic [2:0] axi_awprot, axi_arprot;
    logic [3:0] axi_wstrb;
    logic axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic axi_awready = 0, axi_wready = 0, axi_bvalid = 0, axi_arready = 0, axi_rvalid = 0;
    logic [1:0] axi_bresp = 0, axi_rresp = 0;
    logic [31:0] axi_rdata = 0;
    typedef struct {
        logic [31:0] rd;
        logic [1:0] err;
        int lat;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_pass = 0;
    int aw_delay = 0, aw_n, w_n, ar_n, ar_seen;
    logic ar_hang = 0;
    logic [1:0] bresp_cfg = 0, rresp_cfg = 0;
    logic [31:0] rdata_cfg = 0, rec_awaddr, rec_wdata;
    logic [3:0] rec_wstrb;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic slave_idle();
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
    endtask

    task automatic run_req(input string tag, input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic [1:0] exp_err, input int exp_lat,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
        exp_t e;
        int awc = 0;
        int exp_hs;
        logic got = 0, b_done = 0, r_done = 0;
        @(negedge clk);
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        sb.push_back('{exp_rd, exp_err, exp_lat});
        aw_n = 0; w_n = 0; ar_n = 0; ar_seen = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            req_valid = 0;
            axi_awready = axi_awvalid && awc >= aw_delay;
            if (axi_awvalid) awc++;
            axi_wready = axi_wvalid;
            axi_bvalid = aw_n > 0 && w_n > 0 && !b_done;
            axi_bresp = bresp_cfg;
            axi_arready = axi_arvalid && !ar_hang;
            if (axi_arvalid) ar_seen++;
            axi_rvalid = ar_n > 0 && !r_done;
            axi_rresp = rresp_cfg;
            axi_rdata = rdata_cfg;
            if (axi_awvalid && axi_awready) begin aw_n++; rec_awaddr = axi_awaddr; end
            if (axi_wvalid && axi_wready) begin w_n++; rec_wdata = axi_wdata; rec_wstrb = axi_wstrb; end
            if (axi_bvalid && axi_bready) b_done = 1;
            if (axi_arvalid && axi_arready) ar_n++;
            if (axi_rvalid && axi_rready) r_done = 1;
            if (resp_valid) begin
                got = 1;
                if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
                else begin
                    e = sb.pop_front();
                    check({tag, "_rdata"}, resp_rdata, e.rd);
                    check({tag, "_err"}, resp_err, e.err);
                    check({tag, "_latency"}, c, e.lat);
                    check({tag, "_valids_off"}, {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 0);
                end
            end
        end
        if (!got) check({tag, "_no_resp"}, 0, 1);
        @(negedge clk);
        slave_idle();
        check({tag, "_pulse"}, resp_valid, 0);
        check({tag, "_hold"}, resp_rdata, exp_rd);
        exp_hs = (exp_err == 2'b01 || exp_err == 2'b11) ? 0 : 1;
        if (we) begin
            check({tag, "_aw_n"}, aw_n, exp_hs);
            check({tag, "_w_n"}, w_n, exp_hs);
            if (exp_hs == 1) begin
                check({tag, "_awaddr"}, rec_awaddr, addr);
                check({tag, "_wdata"}, rec_wdata, exp_wdata);
                check({tag, "_wstrb"}, rec_wstrb, exp_wstrb);
            end
        end else begin
            check({tag, "_ar_n"}, ar_n, exp_hs);
            if (exp_err == 2'b01) check({tag, "_ar_seen"}, ar_seen, 0);
        end
    endtask

    initial begin
        int rv;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_resp", {resp_valid, resp_rdata, resp_err}, 0);
        check("rst_axi", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        rst = 0;
        run_req("st_word", 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 2'b00, 3, 32'hDEADBEEF, 4'hF);
        aw_delay = 3;
        run_req("st_byte", 1, 2'd0, 0, 32'h103, 32'hA5, 0, 2'b00, 6, 32'hA500_0000, 4'h8);
        aw_delay = 0;
        run_req("st_half", 1, 2'd1, 0, 32'h102, 32'h1234, 0, 2'b00, 3, 32'h1234_0000, 4'hC);
        bresp_cfg = 2'b10;
        run_req("st_berr", 1, 2'd2, 0, 32'h200, 32'h55, 0, 2'b10, 3, 32'h55, 4'hF);
        bresp_cfg = 2'b00;
        run_req("st_misal", 1, 2'd2, 0, 32'h102, 32'h1, 0, 2'b01, 1, 0, 0);
        rdata_cfg = 32'h0000_8000;
        run_req("ld_sbyte", 0, 2'd0, 1, 32'h101, 0, 32'hFFFF_FF80, 2'b00, 3, 0, 0);
        run_req("ld_ubyte", 0, 2'd0, 0, 32'h101, 0, 32'h0000_0080, 2'b00, 3, 0, 0);
        rdata_cfg = 32'h8001_0000;
        run_req("ld_shalf", 0, 2'd1, 1, 32'h102, 0, 32'hFFFF_8001, 2'b00, 3, 0, 0);
        rdata_cfg = 32'h1234_5678;
        run_req("ld_word", 0, 2'd2, 1, 32'h104, 0, 32'h1234_5678, 2'b00, 3, 0, 0);
        run_req("ld_misal", 0, 2'd1, 0, 32'h101, 0, 0, 2'b01, 1, 0, 0);
        run_req("ld_dword", 0, 2'd3, 0, 32'h100, 0, 0, 2'b01, 1, 0, 0);
        rresp_cfg = 2'b10;
        run_req("ld_rerr", 0, 2'd2, 0, 32'h100, 0, 0, 2'b10, 3, 0, 0);
        rresp_cfg = 2'b00;
        ar_hang = 1;
        run_req("ld_tmo", 0, 2'd2, 0, 32'h100, 0, 0, 2'b11, 8, 0, 0);
        ar_hang = 0;
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h300; req_wdata = 32'h77;
        @(negedge clk);
        req_valid = 0;
        check("rstmid_awvalid", axi_awvalid, 1);
        @(negedge clk);
        rst = 1;
        #1;
        check("rstmid_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        check("rstmid_ready", req_ready, 1);
        @(negedge clk);
        rst = 0;
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        check("rstmid_after_ready", req_ready, 1);
        check("rstmid_no_resp", rv, 0);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
